rv_inst_encoder: RTL

Streaming RISC-V RV32I instruction encoder: takes a format code, register fields, funct3 and a full 32-bit immediate, and emits the 32-bit instruction word. It is the inverse of the immediate generator: it scatters the immediate into the I/S/B/J/U bit positions with range checking. It also expands the LI pseudo-instruction into LUI+ADDI. It sits in the boot/test-program path, feeding instruction memory through a valid/ready stream.

---
 rtl/rv_inst_encoder.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/rv_inst_encoder.sv
// RV32I instruction encoder: scatters a full-width immediate into I/S/B/J/U fields,
// range-checks it, and expands LI into ADDI / LUI / LUI+ADDI on a valid/ready stream.
module rv_inst_encoder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_fmt,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [2:0]  in_funct3,
   input  logic [31:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic        out_last,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, OUT_A, OUT_B} state_t;

   localparam logic [2:0] FMT_LOAD   = 3'd0;
   localparam logic [2:0] FMT_STORE  = 3'd1;
   localparam logic [2:0] FMT_BRANCH = 3'd2;
   localparam logic [2:0] FMT_OPIMM  = 3'd3;
   localparam logic [2:0] FMT_JAL    = 3'd4;
   localparam logic [2:0] FMT_JALR   = 3'd5;
   localparam logic [2:0] FMT_LUI    = 3'd6;
   localparam logic [2:0] FMT_LI     = 3'd7;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
      return {imm, rs1, f3, rd, opc};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
   endfunction

   // imm holds offset bits [12:1]; bit 0 is implicitly zero
   function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:1] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
   endfunction

   function automatic logic [31:0] enc_u(input logic [19:0] upper, input logic [4:0] rd);
      return {upper, rd, OPC_LUI};
   endfunction

   function automatic logic in_range(input logic signed [31:0] v,
                                     input logic signed [31:0] lo,
                                     input logic signed [31:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

   state_t        state_q, state_d;
   logic [31:0]   inst_q, inst_d;
   logic          last_q, last_d;
   logic          err_q, err_d;
   logic [31:0]   pend_q, pend_d;

   logic signed [31:0] imm_s;
   logic               fits12;
   logic               is_shift;
   logic [19:0]        li_hi;
   logic [31:0]        enc_a, enc_b_word;
   logic               enc_single, enc_illegal;
   logic               accept;

   assign imm_s    = in_imm;
   assign fits12   = in_range(imm_s, -32'sd2048, 32'sd2047);
   assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
   // Upper part rounded so that the sign-extended low 12 bits add back exactly
   assign li_hi    = in_imm[31:12] + {19'b0, in_imm[11]};

   always_comb begin
      enc_a       = '0;
      enc_b_word  = '0;
      enc_single  = 1'b1;
      enc_illegal = 1'b0;
      case (in_fmt)
         FMT_LOAD: begin
            enc_illegal = !fits12;
            enc_a       = enc_i(in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD);
         end
         FMT_STORE: begin
            enc_illegal = !fits12;
            enc_a       = enc_s(in_imm[11:0], in_rs2, in_rs1, in_funct3);
         end
         FMT_BRANCH: begin
            enc_illegal = !in_range(imm_s, -32'sd4096, 32'sd4094) || in_imm[0];
            enc_a       = enc_b(in_imm[12:1], in_rs2, in_rs1, in_funct3);
         end
         FMT_OPIMM: begin
            if (is_shift) begin
               enc_illegal = (in_imm[31:11] != '0) || (in_imm[9:5] != '0) ||
                             (in_imm[10] && (in_funct3 != 3'b101));
               enc_a = {1'b0, in_imm[10], 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, OPC_OPIMM};
            end else begin
               enc_illegal = !fits12;
               enc_a       = enc_i(in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_OPIMM);
            end
         end
         FMT_JAL: begin
            enc_illegal = !in_range(imm_s, -32'sd1048576, 32'sd1048574) || in_imm[0];
            enc_a       = enc_j(in_imm[20:1], in_rd);
         end
         FMT_JALR: begin
            enc_illegal = !fits12;
            enc_a       = enc_i(in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_JALR);
         end
         FMT_LUI: begin
            enc_illegal = (in_imm[11:0] != '0);
            enc_a       = enc_u(in_imm[31:12], in_rd);
         end
         FMT_LI: begin
            if (fits12) begin
               enc_a = enc_i(in_imm[11:0], 5'd0, 3'b000, in_rd, OPC_OPIMM);
            end else begin
               enc_a = enc_u(li_hi, in_rd);
               if (in_imm[11:0] != '0) begin
                  enc_single = 1'b0;
                  enc_b_word = enc_i(in_imm[11:0], in_rd, 3'b000, in_rd, OPC_OPIMM);
               end
            end
         end
      endcase
   end

   // In OUT_A, last_q=0 means the ADDI half of an LI is still queued
   always_comb begin
      in_ready = 1'b0;
      case (state_q)
         IDLE:    in_ready = 1'b1;
         OUT_A:   in_ready = out_ready && last_q;
         OUT_B:   in_ready = out_ready;
         default: in_ready = 1'b0;
      endcase
   end

   assign accept = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      inst_d  = inst_q;
      last_d  = last_q;
      pend_d  = pend_q;
      err_d   = 1'b0;
      case (state_q)
         OUT_A: begin
            if (out_ready) begin
               if (!last_q) begin
                  state_d = OUT_B;
                  inst_d  = pend_q;
                  last_d  = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         OUT_B: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = state_q;
      endcase
      if (accept) begin
         if (enc_illegal) begin
            err_d   = 1'b1;
            state_d = IDLE;
         end else begin
            state_d = OUT_A;
            inst_d  = enc_a;
            last_d  = enc_single;
            pend_d  = enc_b_word;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         inst_q  <= '0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         inst_q  <= inst_d;
         last_q  <= last_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      pend_q <= pend_d;
   end

   assign out_valid = (state_q != IDLE);
   assign out_inst  = inst_q;
   assign out_last  = last_q;
   assign err       = err_q;

endmodule
